// File: rtl/alu_multicycle.sv
// alu_multicycle: clocked, multi-cycle ALU between register read and writeback.
// Single-cycle ops finish one cycle after accept. MUL (shift-add) and DIV/MOD
// (restoring division) iterate one bit per cycle for WIDTH cycles.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; in_ready is high only in IDLE, out_valid only in DONE, and DONE holds the
// result stable until out_ready is seen high.
// Optional feature: define ALU_MC_OVERFLOW_EN to add the 'overflow' output.
// dbg_state exposes the FSM state for observation.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [5:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluResult,
  output logic             zero,
  output logic             div_by_zero,
`ifdef ALU_MC_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic [2:0]       dbg_state
);

  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_AND  = 6'b000011;
  localparam logic [5:0] OP_OR   = 6'b000100;
  localparam logic [5:0] OP_XOR  = 6'b000101;
  localparam logic [5:0] OP_NOT  = 6'b000110;
  localparam logic [5:0] OP_SLL  = 6'b000111;
  localparam logic [5:0] OP_SRL  = 6'b001000;
  localparam logic [5:0] OP_MUL  = 6'b001001;
  localparam logic [5:0] OP_DIV  = 6'b001010;
  localparam logic [5:0] OP_MOD  = 6'b001011;
  localparam logic [5:0] OP_PASSB = 6'b100000;
  localparam logic [5:0] OP_SUB2 = 6'b100001;
  localparam logic [5:0] OP_EQ   = 6'b100010;

  // Shift amounts at or above this limit produce zero.
  localparam logic [WIDTH-1:0] SH_LIM = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(WIDTH);

`ifdef ALU_MC_OVERFLOW_EN
  // Full double-width product so bits above WIDTH can flag overflow.
  localparam int PW = 2 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nx;

  // Operands and opcode captured at accept.
  logic [WIDTH-1:0] op_a, op_b;
  logic [5:0]       opc;
  logic [CNT_W-1:0] cnt;

  // Multiplier working registers.
  logic [PW-1:0]    acc, mcand;
  logic [WIDTH-1:0] mplier;

  // Divider working registers: partial remainder and dividend/quotient shifter.
  logic [WIDTH-1:0] rem, quot;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;

  logic             accept;
  logic             iter_last;
  logic             load_res;
  logic [WIDTH-1:0] exec_res;
  logic [WIDTH-1:0] res_nx;
  logic             dbz_nx;
`ifdef ALU_MC_OVERFLOW_EN
  logic             exec_ovf;
  logic             ovf_nx;
`endif

  assign accept    = in_valid && (state == S_IDLE);
  assign iter_last = (cnt == '0);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign dbg_state = state;

  // One restoring-division step: shift in next dividend bit, subtract if it fits.
  // When rem_sh >= op_b the true difference is below 2^WIDTH, so the modular
  // WIDTH-bit subtraction is exact.
  assign rem_sh  = {rem, quot[WIDTH-1]};
  assign rem_ge  = (rem_sh >= {1'b0, op_b});
  assign rem_sub = rem_sh[WIDTH-1:0] - op_b;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; MUL/DIV leave only when the counter has reached zero.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (operation == OP_MUL)                              state_nx = S_MUL;
          else if (operation == OP_DIV || operation == OP_MOD) state_nx = S_DIV;
          else                                                  state_nx = S_EXEC;
        end
      end
      S_EXEC: state_nx = S_DONE;
      S_MUL:  if (iter_last) state_nx = S_DONE;
      S_DIV:  if (iter_last) state_nx = S_DONE;
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Single-cycle operation results from the latched operands.
  always_comb begin
    exec_res = op_a;
    unique case (opc)
      OP_ADD:   exec_res = op_a + op_b;
      OP_SUB:   exec_res = op_a - op_b;
      OP_AND:   exec_res = op_a & op_b;
      OP_OR:    exec_res = op_a | op_b;
      OP_XOR:   exec_res = op_a ^ op_b;
      OP_NOT:   exec_res = ~op_a;
      OP_SLL:   exec_res = (op_b >= SH_LIM) ? '0 : (op_a << op_b);
      OP_SRL:   exec_res = (op_b >= SH_LIM) ? '0 : (op_a >> op_b);
      OP_PASSB: exec_res = op_b;
      OP_SUB2:  exec_res = op_a - op_b;
      OP_EQ:    exec_res = {{(WIDTH-1){1'b0}}, (op_a == op_b)};
      default:  exec_res = op_a;
    endcase
  end

`ifdef ALU_MC_OVERFLOW_EN
  // Signed overflow: result sign differs from a when operand signs make that impossible.
  always_comb begin
    exec_ovf = 1'b0;
    if (opc == OP_ADD)
      exec_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (exec_res[WIDTH-1] != op_a[WIDTH-1]);
    else if (opc == OP_SUB || opc == OP_SUB2)
      exec_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (exec_res[WIDTH-1] != op_a[WIDTH-1]);
  end
`endif

  // Select what the result registers load, and when.
  always_comb begin
    load_res = 1'b0;
    res_nx   = exec_res;
    dbz_nx   = 1'b0;
`ifdef ALU_MC_OVERFLOW_EN
    ovf_nx   = 1'b0;
`endif
    if (state == S_EXEC) begin
      load_res = 1'b1;
`ifdef ALU_MC_OVERFLOW_EN
      ovf_nx   = exec_ovf;
`endif
    end else if (state == S_MUL && iter_last) begin
      load_res = 1'b1;
      res_nx   = acc[WIDTH-1:0];
`ifdef ALU_MC_OVERFLOW_EN
      ovf_nx   = |acc[PW-1:WIDTH];
`endif
    end else if (state == S_DIV && iter_last) begin
      load_res = 1'b1;
      res_nx   = (opc == OP_MOD) ? rem : quot;
      dbz_nx   = (op_b == '0);
    end
  end

  // Operand capture, iteration counter and MUL/DIV working registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_a   <= '0;
      op_b   <= '0;
      opc    <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quot   <= '0;
    end else if (accept) begin
      op_a   <= data1;
      op_b   <= data2;
      opc    <= operation;
      cnt    <= CNT_START;
      acc    <= '0;
      mcand  <= PW'(data1);
      mplier <= data2;
      rem    <= '0;
      quot   <= data1;
    end else if (state == S_MUL && !iter_last) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end else if (state == S_DIV && !iter_last) begin
      rem    <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
      quot   <= {quot[WIDTH-2:0], rem_ge};
      cnt    <= cnt - 1'b1;
    end
  end

  // Result registers: load once per operation and hold through DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aluResult   <= '0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
    end else if (load_res) begin
      aluResult   <= res_nx;
      zero        <= (res_nx == '0);
      div_by_zero <= dbz_nx;
    end
  end

`ifdef ALU_MC_OVERFLOW_EN
  // Overflow flag, registered alongside the result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         overflow <= 1'b0;
    else if (load_res) overflow <= ovf_nx;
  end
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed plus random checks of alu_multicycle against a
// plain-arithmetic reference model. Inputs are driven on the falling edge side,
// outputs sampled on the falling edge.
module tb_alu_multicycle;
  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data1, data2;
  logic [5:0]   operation;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] aluResult;
  logic         zero;
  logic         div_by_zero;
`ifdef ALU_MC_OVERFLOW_EN
  logic         overflow;
`endif
  logic [2:0]   dbg_state;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic         dbz_q[$];
  logic         ovf_q[$];

  alu_multicycle #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data1(data1),
    .data2(data2),
    .operation(operation),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .aluResult(aluResult),
    .zero(zero),
    .div_by_zero(div_by_zero),
`ifdef ALU_MC_OVERFLOW_EN
    .overflow(overflow),
`endif
    .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: unsigned mod-2^W arithmetic written directly from the op table.
  function automatic void model(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic dbz, output logic ovf);
    longint       sa, sb, s;
    logic [2*W-1:0] p;
    dbz = 1'b0;
    ovf = 1'b0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (op)
      6'b000001: begin r = a + b; s = sa + sb; ovf = (s != longint'($signed(r))); end
      6'b000010: begin r = a - b; s = sa - sb; ovf = (s != longint'($signed(r))); end
      6'b000011: r = a & b;
      6'b000100: r = a | b;
      6'b000101: r = a ^ b;
      6'b000110: r = ~a;
      6'b000111: r = (b >= W) ? '0 : a << b;
      6'b001000: r = (b >= W) ? '0 : a >> b;
      6'b001001: begin
        p   = (2*W)'(a) * (2*W)'(b);
        r   = p[W-1:0];
        ovf = (p[2*W-1:W] != '0);
      end
      6'b001010: begin
        dbz = (b == '0);
        r   = dbz ? '1 : a / b;
      end
      6'b001011: begin
        dbz = (b == '0);
        r   = dbz ? a : a % b;
      end
      6'b100000: r = b;
      6'b100001: begin r = a - b; s = sa - sb; ovf = (s != longint'($signed(r))); end
      6'b100010: r = (a == b) ? W'(1) : '0;
      default:   r = a;
    endcase
  endfunction

  // Driver: issue one op, scoreboard it, check latency, result, hold and release.
  task automatic run_op(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    logic [W-1:0] er, got;
    logic         ed, eo, eg_dbz, eg_ovf;
    logic         busy_ready;
    int           lat, exp_lat;
    model(op, a, b, er, ed, eo);
    exp_q.push_back(er);
    dbz_q.push_back(ed);
    ovf_q.push_back(eo);
    exp_lat = (op == 6'b001001 || op == 6'b001010 || op == 6'b001011) ? W + 1 : 1;

    @(negedge clock);
    chk("in_ready_idle", 64'(in_ready), 64'(1));
    in_valid  = 1'b1;
    data1     = a;
    data2     = b;
    operation = op;
    out_ready = (hold == 0);
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    data1     = $urandom;
    data2     = $urandom;
    operation = 6'($urandom);

    lat = 0;
    busy_ready = 1'b0;
    @(negedge clock);
    while (out_valid !== 1'b1 && lat < 3 * W) begin
      if (in_ready !== 1'b0) busy_ready = 1'b1;
      @(negedge clock);
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_in_ready", 64'(busy_ready), 64'(0));

    got    = exp_q.pop_front();
    eg_dbz = dbz_q.pop_front();
    eg_ovf = ovf_q.pop_front();
    chk("result", 64'(aluResult), 64'(got));
    chk("zero", 64'(zero), 64'(got == '0));
    chk("div_by_zero", 64'(div_by_zero), 64'(eg_dbz));
`ifdef ALU_MC_OVERFLOW_EN
    chk("overflow", 64'(overflow), 64'(eg_ovf));
`endif

    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold_out_valid", 64'(out_valid), 64'(1));
      chk("hold_result", 64'(aluResult), 64'(got));
      chk("hold_zero", 64'(zero), 64'(got == '0));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
    end

    out_ready = 1'b1;
    @(negedge clock);
    chk("release_out_valid", 64'(out_valid), 64'(0));
    chk("release_in_ready", 64'(in_ready), 64'(1));
  endtask

  logic [5:0] op_tbl[15] = '{6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
                            6'b000110, 6'b000111, 6'b001000, 6'b001001, 6'b001010,
                            6'b001011, 6'b100000, 6'b100001, 6'b100010, 6'b111111};

  initial begin
    logic         seen_valid;
    logic [5:0]   rop;
    logic [W-1:0] ra, rb;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data1     = '0;
    data2     = '0;
    operation = '0;
    repeat (3) @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_result", 64'(aluResult), 64'(0));
    chk("rst_zero", 64'(zero), 64'(1));
    chk("rst_dbz", 64'(div_by_zero), 64'(0));
    reset = 1'b0;

    // Add with signed overflow, then long multiply with product wrapping to 0.
    run_op(6'b000001, 32'h7FFF_FFFF, 32'h1, 0);
    run_op(6'b001001, 32'h0001_0000, 32'h0001_0000, 0);
    run_op(6'b001001, 32'd12345, 32'd678, 0);

    // Division, remainder and divide by zero.
    run_op(6'b001010, 32'd100, 32'd7, 0);
    run_op(6'b001011, 32'd100, 32'd7, 0);
    run_op(6'b001010, 32'd5, 32'd0, 0);
    run_op(6'b001011, 32'd5, 32'd0, 0);

    // Shifts, passthrough of undefined opcode, equality.
    run_op(6'b000111, 32'd1, 32'd40, 0);
    run_op(6'b001000, 32'h8000_0000, 32'd31, 0);
    run_op(6'b111111, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    run_op(6'b100010, 32'd9, 32'd9, 0);

    // Backpressure: result held for 5 cycles with out_ready low.
    run_op(6'b000010, 32'd3, 32'd3, 5);

    // Reset in the middle of a divide; nothing may come out afterwards.
    @(negedge clock);
    in_valid  = 1'b1;
    data1     = 32'd1000;
    data2     = 32'd3;
    operation = 6'b001010;
    out_ready = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_result", 64'(aluResult), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_zero", 64'(zero), 64'(1));
    @(negedge clock);
    reset = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b0) seen_valid = 1'b1;
    end
    chk("no_result_after_reset", 64'(seen_valid), 64'(0));
    run_op(6'b000001, 32'd2, 32'd2, 0);

    // Random operations across the opcode set, with occasional backpressure.
    for (int n = 0; n < 40; n++) begin
      rop = op_tbl[$urandom_range(0, 14)];
      if ($urandom_range(0, 4) == 0) rop = 6'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = W'($urandom_range(0, 40));
        2:       rb = ra;
        default: rb = W'($urandom);
      endcase
      run_op(rop, ra, rb, ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
